// File: rtl/riscv_i32c_fetch_aligner_pkg.sv
// Shared types for the RV32IC instruction-fetch aligner: fetch FSM states,
// SRAM geometry default and the imem access request/response records.
package riscv_i32c_fetch_aligner_pkg;

    localparam int SRAM_ADDR_WIDTH_DEFAULT = 14;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_HI = 2'd1,
        DONE     = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] address;
        logic        read_enable;
        logic        write_enable;
        logic [3:0]  byte_enable;
        logic [31:0] write_data;
    } imem_access_req_t;

    // 'wait' is a keyword, so the stall flag carries a different field name
    typedef struct packed {
        logic        stall;
        logic [31:0] read_data;
    } imem_access_resp_t;

endpackage

// File: rtl/riscv_i32c_fetch_aligner_if.sv
// Core-side imem access bus: the core drives the request, the aligner answers.
interface riscv_i32c_fetch_aligner_if;

    logic [31:0] imem_access_req__address;
    logic        imem_access_req__read_enable;
    logic        imem_access_req__write_enable;
    logic [3:0]  imem_access_req__byte_enable;
    logic [31:0] imem_access_req__write_data;
    logic        imem_access_resp__wait;
    logic [31:0] imem_access_resp__read_data;

    modport master (
        output imem_access_req__address, imem_access_req__read_enable,
               imem_access_req__write_enable, imem_access_req__byte_enable,
               imem_access_req__write_data,
        input  imem_access_resp__wait, imem_access_resp__read_data
    );

    modport slave (
        input  imem_access_req__address, imem_access_req__read_enable,
               imem_access_req__write_enable, imem_access_req__byte_enable,
               imem_access_req__write_data,
        output imem_access_resp__wait, imem_access_resp__read_data
    );

endinterface

// File: rtl/riscv_i32c_fetch_aligner_word_buffer.sv
// One-word SRAM read buffer (valid/tag/data) for the fetch aligner.
// Only built when RISCV_FETCH_ALIGNER_BUFFER_EN is defined.
`ifdef RISCV_FETCH_ALIGNER_BUFFER_EN
module riscv_fetch_word_buffer #(
    parameter int TAG_W = 14
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [TAG_W-1:0] i_load_tag,
    input  logic [31:0]      i_load_data,
    input  logic             i_flush,
    input  logic [TAG_W-1:0] i_lookup_tag,
    output logic             o_hit,
    output logic [31:0]      o_data
);

    logic             r_valid;
    logic [TAG_W-1:0] r_tag;
    logic [31:0]      r_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_tag   <= i_load_tag;
            r_data  <= i_load_data;
        end
    end

    // A flush in the same cycle as a lookup must force a miss
    assign o_hit  = r_valid && !i_flush && (r_tag == i_lookup_tag);
    assign o_data = r_data;

endmodule
`endif

// File: rtl/riscv_i32c_fetch_aligner.sv
// Halfword-aligned 32-bit instruction fetch over a word-wide read-only SRAM.
// Define RISCV_FETCH_ALIGNER_BUFFER_EN to add a one-word buffer that lets a
// misaligned fetch reuse the previously read word as its low half.
module riscv_i32c_fetch_aligner
    import riscv_i32c_fetch_aligner_pkg::*;
#(
    parameter int SRAM_ADDR_WIDTH = SRAM_ADDR_WIDTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset_n,
    riscv_i32c_fetch_aligner_if.slave  imem,
    input  logic                       flush,
    output logic                       sram_select,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_address,
    input  logic [31:0]                sram_read_data
);

    localparam logic [SRAM_ADDR_WIDTH-1:0] IDX_ONE = {{(SRAM_ADDR_WIDTH-1){1'b0}}, 1'b1};

    imem_access_req_t            w_req;
    imem_access_resp_t           w_resp;
    fetch_state_e                r_state;
    fetch_state_e                w_state_next;
    logic [31:0]                 r_hold;
    logic [SRAM_ADDR_WIDTH-1:0]  r_lo_idx;
    logic                        r_mis;
    logic [SRAM_ADDR_WIDTH-1:0]  w_lo_idx;
    logic                        w_mis;
    logic                        w_hit;
    logic [31:0]                 w_buf_data;
    logic                        w_unused;

    assign w_req = '{
        address:      imem.imem_access_req__address,
        read_enable:  imem.imem_access_req__read_enable,
        write_enable: imem.imem_access_req__write_enable,
        byte_enable:  imem.imem_access_req__byte_enable,
        write_data:   imem.imem_access_req__write_data
    };

    assign w_lo_idx = w_req.address[SRAM_ADDR_WIDTH+1:2];
    assign w_mis    = w_req.address[1];

    assign imem.imem_access_resp__wait      = w_resp.stall;
    assign imem.imem_access_resp__read_data = w_resp.read_data;

    // Write side of the bus is meaningless for read-only instruction memory
    assign w_unused = ^{w_req.address, w_req.write_enable, w_req.byte_enable,
                        w_req.write_data, flush};

`ifdef RISCV_FETCH_ALIGNER_BUFFER_EN
    logic                       r_rd_vld;
    logic [SRAM_ADDR_WIDTH-1:0] r_rd_idx;

    // Remember what was selected so the returning word can be tagged
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_vld <= 1'b0;
            r_rd_idx <= '0;
        end else begin
            r_rd_vld <= sram_select;
            r_rd_idx <= sram_address;
        end
    end

    riscv_fetch_word_buffer #(
        .TAG_W (SRAM_ADDR_WIDTH)
    ) u_buf (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_load       (r_rd_vld),
        .i_load_tag   (r_rd_idx),
        .i_load_data  (sram_read_data),
        .i_flush      (flush),
        .i_lookup_tag (w_lo_idx),
        .o_hit        (w_hit),
        .o_data       (w_buf_data)
    );
`else
    assign w_hit      = 1'b0;
    assign w_buf_data = '0;
`endif

    always_comb begin
        w_state_next = r_state;
        sram_select  = 1'b0;
        sram_address = '0;
        w_resp       = '0;
        case (r_state)
            IDLE: begin
                if (w_req.read_enable) begin
                    sram_select  = 1'b1;
                    w_resp.stall = 1'b1;
                    if (w_mis && w_hit) begin
                        sram_address = w_lo_idx + IDX_ONE;
                        w_state_next = DONE;
                    end else begin
                        sram_address = w_lo_idx;
                        w_state_next = w_mis ? FETCH_HI : DONE;
                    end
                end
            end
            FETCH_HI: begin
                if (w_req.read_enable) begin
                    sram_select  = 1'b1;
                    sram_address = r_lo_idx + IDX_ONE;
                    w_resp.stall = 1'b1;
                    w_state_next = DONE;
                end else begin
                    w_state_next = IDLE;
                end
            end
            DONE: begin
                w_resp.read_data = r_mis ? {sram_read_data[15:0], r_hold[31:16]}
                                         : sram_read_data;
                w_state_next     = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_hold   <= '0;
            r_lo_idx <= '0;
            r_mis    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && w_req.read_enable) begin
                r_lo_idx <= w_lo_idx;
                r_mis    <= w_mis;
                if (w_mis && w_hit)
                    r_hold <= w_buf_data;
            end else if (r_state == FETCH_HI) begin
                r_hold <= sram_read_data;
            end
        end
    end

endmodule

// File: tb/tb_riscv_i32c_fetch_aligner.sv
// Directed scoreboard bench for the fetch aligner: the driver queues the
// hand-computed response of each fetch, the monitor checks what comes back.
module tb_riscv_i32c_fetch_aligner;

    localparam int AW = 14;
`ifdef RISCV_FETCH_ALIGNER_BUFFER_EN
    localparam int HITC = 1;
`else
    localparam int HITC = 2;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          sram_select;
    logic [AW-1:0] sram_address;
    logic [31:0]   sram_read_data = '0;
    logic [31:0]   mem [0:(1<<AW)-1];

    riscv_i32c_fetch_aligner_if bus ();

    riscv_i32c_fetch_aligner #(.SRAM_ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem           (bus),
        .flush          (flush),
        .sram_select    (sram_select),
        .sram_address   (sram_address),
        .sram_read_data (sram_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (sram_select) sram_read_data <= mem[sram_address];

    typedef struct {
        string         tag;
        logic [31:0]   data;
        int            waits;
        int            sels;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    int            n_tests = 0;
    int            n_fail = 0;
    int            m_waits = 0;
    int            m_sels = 0;
    logic [AW-1:0] m_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a response is a cycle with read_enable high and wait low
    always @(negedge clk) begin
        if (!reset_n || !bus.imem_access_req__read_enable) begin
            m_waits = 0;
            m_sels  = 0;
        end else begin
            if (sram_select) begin
                m_sels++;
                m_addr = sram_address;
            end
            if (bus.imem_access_resp__wait) begin
                m_waits++;
            end else begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_response: got %h expected none",
                             bus.imem_access_resp__read_data);
                end else begin
                    e = sb.pop_front();
                    chk({e.tag, ".data"}, bus.imem_access_resp__read_data, e.data);
                    chk({e.tag, ".waits"}, 32'(m_waits), 32'(e.waits));
                    chk({e.tag, ".selects"}, 32'(m_sels), 32'(e.sels));
                    chk({e.tag, ".last_sram_addr"}, 32'(m_addr), 32'(e.addr));
                end
                m_waits = 0;
                m_sels  = 0;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 with read_enable low
    task automatic fetch(input string tag, input logic [31:0] addr, input bit we, input bit fl,
                         input logic [31:0] exp_data, input int ew, input int es,
                         input logic [AW-1:0] ea);
        bit done = 0;
        int n = 0;
        exp_t x;
        x.tag = tag; x.data = exp_data; x.waits = ew; x.sels = es; x.addr = ea;
        sb.push_back(x);
        bus.imem_access_req__address      = addr;
        bus.imem_access_req__read_enable  = 1'b1;
        bus.imem_access_req__write_enable = we;
        bus.imem_access_req__byte_enable  = we ? 4'hF : 4'($urandom);
        bus.imem_access_req__write_data   = $urandom;
        flush = fl;
        while (!done && n < 10) begin
            @(negedge clk);
            if (!bus.imem_access_resp__wait) done = 1;
            @(posedge clk); #1;
            flush = 1'b0;
            n++;
        end
        bus.imem_access_req__read_enable  = 1'b0;
        bus.imem_access_req__write_enable = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.timeout: got no response expected one within 10 cycles", tag);
        end
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        bus.imem_access_req__address      = '0;
        bus.imem_access_req__read_enable  = 1'b0;
        bus.imem_access_req__write_enable = 1'b0;
        bus.imem_access_req__byte_enable  = '0;
        bus.imem_access_req__write_data   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.select", 32'(sram_select), 32'd0);
        chk("reset.wait", 32'(bus.imem_access_resp__wait), 32'd0);
        chk("reset.read_data", bus.imem_access_resp__read_data, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        mem[14'h40] = 32'h00A00093;
        fetch("aligned", 32'h100, 0, 0, 32'h00A00093, 1, 1, 14'h40);
        pulse_flush();
        mem[14'h40] = 32'h1234ABCD;
        mem[14'h41] = 32'h5678EF01;
        fetch("misaligned", 32'h102, 0, 0, 32'hEF011234, 2, 2, 14'h41);
        fetch("al_before_hit", 32'h100, 0, 0, 32'h1234ABCD, 1, 1, 14'h40);
        fetch("buffer_hit", 32'h102, 0, 0, 32'hEF011234, HITC, HITC, 14'h41);
        fetch("al_before_flush", 32'h100, 0, 0, 32'h1234ABCD, 1, 1, 14'h40);
        pulse_flush();
        fetch("after_flush", 32'h102, 0, 0, 32'hEF011234, 2, 2, 14'h41);
        fetch("al_before_flushreq", 32'h100, 0, 0, 32'h1234ABCD, 1, 1, 14'h40);
        fetch("flush_with_req", 32'h102, 0, 1, 32'hEF011234, 2, 2, 14'h41);

        mem[14'h3FFF] = 32'hAAAA5555;
        mem[14'h0000] = 32'h0000BEEF;
        fetch("top_wrap", 32'h0000FFFE, 0, 0, 32'hBEEFAAAA, 2, 2, 14'h0);
        fetch("top_aligned", 32'h0000FFFC, 0, 0, 32'hAAAA5555, 1, 1, 14'h3FFF);
        fetch("high_bits_ignored", 32'h00010100, 0, 0, 32'h1234ABCD, 1, 1, 14'h40);
        fetch("bit0_ignored", 32'h00000103, 0, 0, 32'hEF011234, HITC, HITC, 14'h41);
        fetch("write_ignored", 32'h104, 1, 0, 32'h5678EF01, 1, 1, 14'h41);
        fetch("reread_after_write", 32'h104, 0, 0, 32'h5678EF01, 1, 1, 14'h41);

        // Abandon a misaligned fetch in FETCH_HI
        mem[14'h80] = 32'h11112222;
        mem[14'h81] = 32'h33334444;
        bus.imem_access_req__address     = 32'h202;
        bus.imem_access_req__read_enable = 1'b1;
        @(posedge clk); #1;
        bus.imem_access_req__read_enable = 1'b0;
        @(negedge clk);
        chk("drop.fetch_hi_select", 32'(sram_select), 32'd0);
        chk("drop.fetch_hi_wait", 32'(bus.imem_access_resp__wait), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drop.no_done_read_data", bus.imem_access_resp__read_data, 32'd0);
        chk("drop.idle_select", 32'(sram_select), 32'd0);
        @(posedge clk); #1;
        fetch("after_drop", 32'h202, 0, 0, 32'h44441111, HITC, HITC, 14'h81);

        // Reset in FETCH_HI must abandon the fetch and empty the buffer
        fetch("pre_reset", 32'h100, 0, 0, 32'h1234ABCD, 1, 1, 14'h40);
        bus.imem_access_req__address     = 32'h302;
        bus.imem_access_req__read_enable = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        bus.imem_access_req__read_enable = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midreset.select", 32'(sram_select), 32'd0);
        chk("midreset.wait", 32'(bus.imem_access_resp__wait), 32'd0);
        chk("midreset.read_data", bus.imem_access_resp__read_data, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        fetch("post_reset_miss", 32'h102, 0, 0, 32'hEF011234, 2, 2, 14'h41);

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
